// File: rtl/fifo_hdl_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// The accumulator state is visible on the top level for checker binding.
package fifo_hdl_pkg;

  typedef enum logic [1:0] {
    ACC_EMPTY = 2'd0,
    ACC_PART  = 2'd1,
    ACC_FULL  = 2'd2
  } acc_state_e;

  // Ceiling log2, evaluated at elaboration time for counter widths.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pack_out_slot.sv
// Output beat register of the packer.
// Holds one packed beat and offers it on a valid/ready stream.
module pack_out_slot #(
  parameter int                DSIZE     = 8,
  parameter int                LANES     = 4,
  parameter logic [DSIZE-1:0]  PAD_VALUE = '0
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst_n,
  input  logic                     load,
  input  logic [DSIZE*LANES-1:0]   load_data,
  input  logic [LANES-1:0]         load_keep,
  input  logic                     out_ready,
  output logic [DSIZE*LANES-1:0]   out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_valid,
  output logic                     slot_free
);

  // Handshake: a beat transfers on a clock edge where out_valid && out_ready.
  // Once out_valid is high, out_data/out_keep stay frozen until that transfer.
  // load is only asserted by the owner while slot_free, so a load in the same
  // cycle as a transfer replaces the departing beat without a bubble.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      out_valid <= 1'b0;
      out_keep  <= '0;
      out_data  <= {LANES{PAD_VALUE}};
    end else if (load) begin
      out_valid <= 1'b1;
      out_keep  <= load_keep;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops words from a first-word-fall-through FIFO and packs LANES of them into
// one wide valid/ready beat; partial beats leave on flush or idle timeout.
module fifo_rd_packer
  import fifo_hdl_pkg::*;
#(
  parameter int                DSIZE     = 8,
  parameter int                LANES     = 4,
  parameter int                TIMEOUT   = 16,
  parameter logic [DSIZE-1:0]  PAD_VALUE = '0
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst_n,
  input  logic                     fifo_empty,
  input  logic [DSIZE-1:0]         fifo_rd_data,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  output logic [DSIZE*LANES-1:0]   out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output acc_state_e               acc_state
);

  localparam int CW   = clog2(LANES + 1);
  localparam int TW   = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  acc_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           timer_q;
  logic                    flush_pend_q;
  logic [DSIZE-1:0]        lane_q [LANES];
  logic [DSIZE-1:0]        lane_d [LANES];
  logic [DSIZE*LANES-1:0]  beat_data;
  logic [LANES-1:0]        beat_keep;
  logic                    capture;
  logic                    flush_req;
  logic                    timeout_hit;
  logic                    promote_req;
  logic                    promote;
  logic                    slot_free;

  // The beat offered to the slot is built from next-state contents, so a word
  // captured in the promoting cycle rides along in that beat.
  always_comb begin
    fifo_rd_en = !fifo_empty && (state_q != ACC_FULL);
    capture    = fifo_rd_en;
    cnt_d      = cnt_q + CW'(capture);
    beat_data  = '0;
    beat_keep  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_d[i] = lane_q[i];
      if (capture && (cnt_q == CW'(i))) begin
        lane_d[i] = fifo_rd_data;
      end
      beat_keep[i] = (CW'(i) < cnt_d);
      beat_data[i*DSIZE +: DSIZE] = beat_keep[i] ? lane_d[i] : PAD_VALUE;
    end
    flush_req   = (flush || flush_pend_q) && (cnt_d != '0);
    timeout_hit = (TIMEOUT != 0) && (state_q == ACC_PART) && (timer_q == TW'(TMAX));
    promote_req = (state_q == ACC_FULL) || (cnt_d == CW'(LANES)) || flush_req || timeout_hit;
    promote     = promote_req && slot_free;
    if (cnt_d == '0) begin
      state_d = ACC_EMPTY;
    end else if (cnt_d == CW'(LANES)) begin
      state_d = ACC_FULL;
    end else begin
      state_d = ACC_PART;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q      <= ACC_EMPTY;
      cnt_q        <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= lane_d[i];
      end
      if (promote) begin
        state_q      <= ACC_EMPTY;
        cnt_q        <= '0;
        timer_q      <= '0;
        flush_pend_q <= 1'b0;
      end else begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        // A flush that could not promote stays armed until the slot frees up.
        flush_pend_q <= flush_req;
        if (capture) begin
          timer_q <= '0;
        end else if ((state_q == ACC_PART) && (timer_q != TW'(TMAX))) begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

  pack_out_slot #(
    .DSIZE     (DSIZE),
    .LANES     (LANES),
    .PAD_VALUE (PAD_VALUE)
  ) u_slot (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .load      (promote),
    .load_data (beat_data),
    .load_keep (beat_keep),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .slot_free (slot_free)
  );

  assign busy      = (state_q != ACC_EMPTY) || out_valid;
  assign acc_state = state_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed and random checks of fifo_rd_packer against a word-order scoreboard.
module tb_fifo_rd_packer;
  import fifo_hdl_pkg::*;

  localparam int          DSIZE   = 8;
  localparam int          LANES   = 4;
  localparam int          TIMEOUT = 16;
  localparam int          W       = DSIZE * LANES;
  localparam logic [7:0]  PAD     = 8'h00;

  logic              rd_clk;
  logic              rd_rst_n;
  logic              fifo_empty;
  logic [DSIZE-1:0]  fifo_rd_data;
  logic              fifo_rd_en;
  logic              flush;
  logic [W-1:0]      out_data;
  logic [LANES-1:0]  out_keep;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  acc_state_e        dbg_state;

  fifo_rd_packer #(
    .DSIZE     (DSIZE),
    .LANES     (LANES),
    .TIMEOUT   (TIMEOUT),
    .PAD_VALUE (PAD)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .acc_state    (dbg_state)
  );

  // Clock / reset block
  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int               n_cmp;
  int               n_err;
  int               cyc;
  int               n_popped;
  int               n_delivered;
  logic             hold_empty;
  logic             prev_stall;
  logic [W-1:0]     prev_data;
  logic [LANES-1:0] prev_keep;
  logic [DSIZE-1:0] src_q[$];
  logic [DSIZE-1:0] exp_q[$];
  logic [W-1:0]     beat_q[$];
  logic [LANES-1:0] bkeep_q[$];
  int               bcyc_q[$];
  int               pop_cyc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [LANES-1:0] k);
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++) n += int'(k[i]);
    return n;
  endfunction

  // Driver: one clock cycle of the FWFT source and the sink, with scoreboard.
  task automatic step(input logic rdy, input logic fl);
    int acc_words;
    int k;
    out_ready    = rdy;
    flush        = fl;
    fifo_empty   = hold_empty || (src_q.size() == 0);
    fifo_rd_data = fifo_empty ? DSIZE'($urandom) : src_q[0];
    #4;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
      chk("hold_keep", out_keep, prev_keep);
    end
    acc_words = n_popped - n_delivered - (out_valid ? popc(out_keep) : 0);
    chk("rd_en", fifo_rd_en, (!fifo_empty && acc_words < LANES));
    chk("busy", busy, (acc_words > 0 || out_valid));
    if (fifo_rd_en && !fifo_empty) begin
      exp_q.push_back(src_q.pop_front());
      n_popped++;
      pop_cyc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      k = popc(out_keep);
      chk("keep_nonzero", (k == 0), 0);
      chk("keep_thermo", out_keep, (1 << k) - 1);
      for (int i = 0; i < LANES; i++) begin
        if (i < k) begin
          if (exp_q.size() == 0) chk("lane_extra_word", 1, 0);
          else chk("lane_data", out_data[i*DSIZE +: DSIZE], exp_q.pop_front());
        end else begin
          chk("lane_pad", out_data[i*DSIZE +: DSIZE], PAD);
        end
      end
      n_delivered += k;
      beat_q.push_back(out_data);
      bkeep_q.push_back(out_keep);
      bcyc_q.push_back(cyc);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_keep  = out_keep;
    @(posedge rd_clk);
    #1;
    cyc++;
  endtask

  initial begin
    int nb;
    int np;
    int mode;
    logic [W-1:0] expd;
    n_cmp = 0; n_err = 0; cyc = 0; n_popped = 0; n_delivered = 0;
    hold_empty = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_keep = '0;
    rd_rst_n = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge rd_clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_data", out_data, {LANES{PAD}});
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, ACC_EMPTY);
    chk("rst_rd_en", fifo_rd_en, 0);
    rd_rst_n = 1'b1;

    // Four back-to-back words form one full beat one cycle after the last pop
    nb = beat_q.size(); np = pop_cyc_q.size();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (8) step(1'b1, 1'b0);
    chk("t1_pops", pop_cyc_q.size() - np, 4);
    chk("t1_beats", beat_q.size() - nb, 1);
    if (pop_cyc_q.size() - np == 4) chk("t1_pop_run", pop_cyc_q[np+3] - pop_cyc_q[np], 3);
    if (beat_q.size() > nb && pop_cyc_q.size() - np == 4) begin
      chk("t1_data", beat_q[nb], 32'h44332211);
      chk("t1_keep", bkeep_q[nb], 4'b1111);
      chk("t1_latency", bcyc_q[nb] - pop_cyc_q[np+3], 1);
    end

    // Two words then idle: timeout promotes a padded partial beat
    nb = beat_q.size();
    src_q.push_back(8'hA1); src_q.push_back(8'hA2);
    for (int i = 0; i < 40 && beat_q.size() == nb; i++) step(1'b1, 1'b0);
    chk("t2_beat_seen", beat_q.size() > nb, 1);
    if (beat_q.size() > nb) begin
      chk("t2_data", beat_q[nb], 32'h0000A2A1);
      chk("t2_keep", bkeep_q[nb], 4'b0011);
      chk("t2_idle_gap", bcyc_q[nb] - pop_cyc_q[pop_cyc_q.size()-1], TIMEOUT + 1);
    end

    // Flush together with the third capture
    nb = beat_q.size();
    src_q = '{8'hAA, 8'hBB, 8'hCC};
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    np = pop_cyc_q[pop_cyc_q.size()-1];
    for (int i = 0; i < 10 && beat_q.size() == nb; i++) step(1'b1, 1'b0);
    chk("t3_beat_seen", beat_q.size() > nb, 1);
    if (beat_q.size() > nb) begin
      chk("t3_data", beat_q[nb], 32'h00CCBBAA);
      chk("t3_keep", bkeep_q[nb], 4'b0111);
      chk("t3_latency", bcyc_q[nb] - np, 1);
    end

    // Backpressure: 12 words with the sink stalled for 10 cycles
    nb = beat_q.size(); np = pop_cyc_q.size();
    for (int i = 0; i < 12; i++) src_q.push_back(DSIZE'(8'h40 + i));
    repeat (10) step(1'b0, 1'b0);
    chk("t4_pops_stalled", pop_cyc_q.size() - np, 8);
    chk("t4_beats_stalled", beat_q.size() - nb, 0);
    for (int i = 0; i < 30 && beat_q.size() < nb + 3; i++) step(1'b1, 1'b0);
    chk("t4_beats", beat_q.size() - nb, 3);
    for (int j = 0; j < 3; j++) begin
      if (beat_q.size() > nb + j) begin
        for (int l = 0; l < LANES; l++) expd[l*DSIZE +: DSIZE] = DSIZE'(8'h40 + 4*j + l);
        chk("t4_data", beat_q[nb+j], expd);
        chk("t4_keep", bkeep_q[nb+j], 4'b1111);
      end
    end

    // Reset with a beat in the slot and two words in the accumulator
    src_q = '{8'h50, 8'h51, 8'h52, 8'h53};
    repeat (6) step(1'b0, 1'b0);
    src_q.push_back(8'h60); src_q.push_back(8'h61);
    repeat (2) step(1'b0, 1'b0);
    fifo_empty = 1'b1;
    rd_rst_n   = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_keep", out_keep, 0);
    chk("t5_busy", busy, 0);
    chk("t5_state", dbg_state, ACC_EMPTY);
    @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    src_q.delete(); exp_q.delete();
    n_popped = 0; n_delivered = 0; prev_stall = 1'b0;
    nb = beat_q.size();
    src_q = '{8'h70, 8'h71, 8'h72, 8'h73};
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    chk("t5_beats", beat_q.size() - nb, 1);
    if (beat_q.size() > nb) begin
      chk("t5_data", beat_q[nb], 32'h73727170);
      chk("t5_keep_after", bkeep_q[nb], 4'b1111);
    end

    // Random source gaps, sink stalls and flushes
    for (int i = 0; i < 10000; i++) begin
      mode = (i / 256) % 3;
      while (src_q.size() < 3) src_q.push_back(DSIZE'($urandom));
      case (mode)
        0:       hold_empty = 1'b0;
        1:       hold_empty = ($urandom_range(0, 3) == 0);
        default: hold_empty = ($urandom_range(0, 15) != 0);
      endcase
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    hold_empty = 1'b0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || src_q.size() != 0 || busy); i++) step(1'b1, 1'b0);
    chk("drain_src", src_q.size(), 0);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
    chk("drain_count", n_delivered, n_popped);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
